// File: rtl/issue_ctrl_pkg.sv
// issue_ctrl_pkg: shared widths, bit indices and FSM encoding for the issue controller
package issue_ctrl_pkg;
  localparam int NREG          = 16;
  localparam int DIR_W         = $clog2(NREG);
  localparam int FLUSH_CYC_DEF = 2;
  localparam int WB_R   = 0;
  localparam int WB_V   = 1;
  localparam int WB_MEM = 2;
  localparam int SRC_RW = 0;
  localparam int SRC_RZ = 1;
  localparam int SRC_VW = 2;
  localparam int SRC_VZ = 3;
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_STALL_HZ = 2'd1,
    ST_STALL_EX = 2'd2,
    ST_FLUSH    = 2'd3
  } state_e;
endpackage

// File: rtl/issue_ctrl_scoreboard.sv
// issue_ctrl_scoreboard: pending-write bit per register, set on issue, cleared on write-back
module issue_ctrl_scoreboard
  import issue_ctrl_pkg::*;
#(
  parameter bit EXEMPT0 = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_i,
  input  logic [DIR_W-1:0] set_dir_i,
  input  logic             clr_i,
  input  logic [DIR_W-1:0] clr_dir_i,
  input  logic [DIR_W-1:0] rd_a_dir_i,
  input  logic [DIR_W-1:0] rd_b_dir_i,
  input  logic [DIR_W-1:0] rd_c_dir_i,
  output logic             rd_a_o,
  output logic             rd_b_o,
  output logic             rd_c_o,
  output logic [NREG-1:0]  pend_o
);
  logic [NREG-1:0] pend_q, pend_d, set_m, clr_m, keep_m;
  // set is OR-ed after the clear so a same-index set survives the write-back
  always_comb begin
    keep_m    = {NREG{1'b1}};
    keep_m[0] = ~EXEMPT0;
    set_m     = set_i ? (NREG'(1) << set_dir_i) : '0;
    clr_m     = clr_i ? (NREG'(1) << clr_dir_i) : '0;
    pend_d    = ((pend_q & ~clr_m) | set_m) & keep_m;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end
  assign rd_a_o = pend_q[rd_a_dir_i];
  assign rd_b_o = pend_q[rd_b_dir_i];
  assign rd_c_o = pend_q[rd_c_dir_i];
  assign pend_o = pend_q;
endmodule

// File: rtl/issue_ctrl.sv
// issue_ctrl: decode issue gate with scalar/vector hazard scoreboards, flush refill and perf counters
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int FLUSH_CYC = FLUSH_CYC_DEF,
  parameter bit R0_ZERO   = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dec_valid_i,
  input  logic [3:0]       src_use_i,
  input  logic [DIR_W-1:0] rw_dir_i,
  input  logic [DIR_W-1:0] rz_dir_i,
  input  logic [DIR_W-1:0] vw_dir_i,
  input  logic [DIR_W-1:0] vz_dir_i,
  input  logic [DIR_W-1:0] rk_dir_i,
  input  logic [DIR_W-1:0] vk_dir_i,
  input  logic [2:0]       wb_op_i,
  input  logic             ex_ready_i,
  input  logic             flush_i,
  input  logic             wb_r_valid_i,
  input  logic [DIR_W-1:0] wb_r_dir_i,
  input  logic             wb_v_valid_i,
  input  logic [DIR_W-1:0] wb_v_dir_i,
  output logic             issue_o,
  output logic             stall_o,
  output logic [NREG-1:0]  r_pend_o,
  output logic [NREG-1:0]  v_pend_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] issue_cnt_o
);
  localparam int FC_W = (FLUSH_CYC < 1) ? 1 : $clog2(FLUSH_CYC + 1);
  state_e           state_q, state_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, issue_cnt_q, issue_cnt_d;
  logic r_rw, r_rz, r_rk, v_vw, v_vz, v_vk;
  logic raw, waw, hazard, unused_mem;
  // stores carry no destination register, so the memory bit never touches the scoreboards
  assign unused_mem = wb_op_i[WB_MEM];
  issue_ctrl_scoreboard #(.EXEMPT0(R0_ZERO)) u_r_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_i     (issue_o & wb_op_i[WB_R]),
    .set_dir_i (rk_dir_i),
    .clr_i     (wb_r_valid_i),
    .clr_dir_i (wb_r_dir_i),
    .rd_a_dir_i(rw_dir_i),
    .rd_b_dir_i(rz_dir_i),
    .rd_c_dir_i(rk_dir_i),
    .rd_a_o    (r_rw),
    .rd_b_o    (r_rz),
    .rd_c_o    (r_rk),
    .pend_o    (r_pend_o)
  );
  issue_ctrl_scoreboard #(.EXEMPT0(1'b0)) u_v_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_i     (issue_o & wb_op_i[WB_V]),
    .set_dir_i (vk_dir_i),
    .clr_i     (wb_v_valid_i),
    .clr_dir_i (wb_v_dir_i),
    .rd_a_dir_i(vw_dir_i),
    .rd_b_dir_i(vz_dir_i),
    .rd_c_dir_i(vk_dir_i),
    .rd_a_o    (v_vw),
    .rd_b_o    (v_vz),
    .rd_c_o    (v_vk),
    .pend_o    (v_pend_o)
  );
  assign raw    = (src_use_i[SRC_RW] & r_rw) | (src_use_i[SRC_RZ] & r_rz) |
                  (src_use_i[SRC_VW] & v_vw) | (src_use_i[SRC_VZ] & v_vz);
  assign waw    = (wb_op_i[WB_R] & r_rk) | (wb_op_i[WB_V] & v_vk);
  assign hazard = dec_valid_i & (raw | waw);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end
  // FLUSH holds for FLUSH_CYC cycles: leave once the counter would drop to zero
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (flush_i) begin
      state_d = ST_FLUSH;
      fcnt_d  = FC_W'(FLUSH_CYC);
    end else if (state_q == ST_FLUSH) begin
      fcnt_d  = (fcnt_q == '0) ? '0 : fcnt_q - 1'b1;
      state_d = (fcnt_q <= FC_W'(1)) ? ST_RUN : ST_FLUSH;
    end else begin
      state_d = !dec_valid_i ? ST_RUN :
                hazard       ? ST_STALL_HZ :
                !ex_ready_i  ? ST_STALL_EX : ST_RUN;
    end
  end
  // rst_n gating keeps the handshake quiet while reset is held, independent of clk
  always_comb begin
    issue_o = rst_n & dec_valid_i & ~hazard & ex_ready_i & ~flush_i & (state_q != ST_FLUSH);
    stall_o = rst_n & dec_valid_i & ~issue_o & ~flush_i;
  end
  always_comb begin
    stall_cnt_d = (stall_o && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    issue_cnt_d = (issue_o && !(&issue_cnt_q)) ? issue_cnt_q + 1'b1 : issue_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      issue_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end
  assign stall_cnt_o = stall_cnt_q;
  assign issue_cnt_o = issue_cnt_q;
endmodule

// File: tb/tb_issue_ctrl.sv
// tb_issue_ctrl: directed scenarios checked against a per-register pending model every cycle
module tb_issue_ctrl;
  localparam int FC = 2;
  logic clk = 1'b0;
  logic rst_n;
  logic dec_valid, ex_ready, flush, wbrv, wbvv;
  logic [3:0] src_use, rw, rz, vw, vz, rk, vk, wbrd, wbvd;
  logic [2:0] wb_op;
  logic issue, stall, s_issue, s_stall;
  logic [15:0] rpend, vpend, scnt, icnt, s_rpend, s_vpend;
  logic [2:0] s_scnt, s_icnt;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;

  issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .dec_valid_i(dec_valid), .src_use_i(src_use),
    .rw_dir_i(rw), .rz_dir_i(rz), .vw_dir_i(vw), .vz_dir_i(vz),
    .rk_dir_i(rk), .vk_dir_i(vk), .wb_op_i(wb_op), .ex_ready_i(ex_ready),
    .flush_i(flush), .wb_r_valid_i(wbrv), .wb_r_dir_i(wbrd),
    .wb_v_valid_i(wbvv), .wb_v_dir_i(wbvd), .issue_o(issue), .stall_o(stall),
    .r_pend_o(rpend), .v_pend_o(vpend), .stall_cnt_o(scnt), .issue_cnt_o(icnt)
  );
  issue_ctrl #(.CNT_W(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .dec_valid_i(dec_valid), .src_use_i(src_use),
    .rw_dir_i(rw), .rz_dir_i(rz), .vw_dir_i(vw), .vz_dir_i(vz),
    .rk_dir_i(rk), .vk_dir_i(vk), .wb_op_i(wb_op), .ex_ready_i(ex_ready),
    .flush_i(flush), .wb_r_valid_i(wbrv), .wb_r_dir_i(wbrd),
    .wb_v_valid_i(wbvv), .wb_v_dir_i(wbvd), .issue_o(s_issue), .stall_o(s_stall),
    .r_pend_o(s_rpend), .v_pend_o(s_vpend), .stall_cnt_o(s_scnt), .issue_cnt_o(s_icnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: pending flags per register, remaining refill-blocked cycles, plain event counts
  logic [15:0] mrp = '0, mvp = '0;
  int mblk = 0, msc = 0, mic = 0;
  logic m_hz, m_iss, m_stl;
  assign m_hz  = dec_valid && ((src_use[0] && rw != 0 && mrp[rw]) || (src_use[1] && rz != 0 && mrp[rz]) ||
                               (src_use[2] && mvp[vw]) || (src_use[3] && mvp[vz]) ||
                               (wb_op[0] && rk != 0 && mrp[rk]) || (wb_op[1] && mvp[vk]));
  assign m_iss = rst_n && dec_valid && !m_hz && ex_ready && !flush && (mblk == 0);
  assign m_stl = rst_n && dec_valid && !m_iss && !flush;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mrp <= '0; mvp <= '0; mblk <= 0; msc <= 0; mic <= 0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        mrp[i] <= (m_iss && wb_op[0] && rk == i && i != 0) ? 1'b1 : (wbrv && wbrd == i) ? 1'b0 : mrp[i];
        mvp[i] <= (m_iss && wb_op[1] && vk == i) ? 1'b1 : (wbvv && wbvd == i) ? 1'b0 : mvp[i];
      end
      mblk <= flush ? FC : (mblk > 0 ? mblk - 1 : 0);
      msc  <= (m_stl && msc < 65535) ? msc + 1 : msc;
      mic  <= (m_iss && mic < 65535) ? mic + 1 : mic;
    end
  end

  always @(negedge clk) begin
    chk("issue", 32'(issue), 32'(m_iss));
    chk("stall", 32'(stall), 32'(m_stl));
    chk("r_pend", 32'(rpend), 32'(mrp));
    chk("v_pend", 32'(vpend), 32'(mvp));
    chk("stall_cnt", 32'(scnt), 32'(msc));
    chk("issue_cnt", 32'(icnt), 32'(mic));
    chk("sat_stall_cnt", 32'(s_scnt), 32'(msc > 7 ? 7 : msc));
    chk("sat_issue_cnt", 32'(s_icnt), 32'(mic > 7 ? 7 : mic));
  end

  task automatic idle();
    dec_valid = 0; src_use = 0; rw = 0; rz = 0; vw = 0; vz = 0; rk = 0; vk = 0;
    wb_op = 0; ex_ready = 1; flush = 0; wbrv = 0; wbrd = 0; wbvv = 0; wbvd = 0;
  endtask
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic op(input logic [3:0] use_m, input logic [3:0] r_a, input logic [3:0] dst_r,
                    input logic [3:0] dst_v, input logic [2:0] wop);
    idle();
    dec_valid = 1; src_use = use_m; rw = r_a; rk = dst_r; vk = dst_v; wb_op = wop;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1;
    idle();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1 chk("reset_issue_cnt", 32'(icnt), 0);
    step();
    // scalar RAW on r3: three stalled cycles including the write-back cycle
    op(4'b0000, 0, 3, 0, 3'b001);
    #1 chk("a_issue_w", 32'(issue), 1);
    step();
    chk("a_rpend", 32'(rpend), 32'h0008);
    op(4'b0001, 3, 0, 0, 3'b000);
    #1 chk("a_stall1", 32'(stall), 1);
    step();
    #1 chk("a_stall2", 32'(stall), 1);
    step();
    wbrv = 1; wbrd = 3;
    #1 chk("a_stall_wb", 32'(stall), 1);
    step();
    wbrv = 0;
    #1 chk("a_issue_rd", 32'(issue), 1);
    chk("a_stall_cnt", 32'(scnt), 3);
    chk("a_rpend_clr", 32'(rpend), 0);
    step();
    // r0 is never tracked
    op(4'b0000, 0, 0, 0, 3'b001);
    step();
    chk("r0_rpend", 32'(rpend), 0);
    op(4'b0001, 0, 0, 0, 3'b000);
    #1 chk("r0_issue", 32'(issue), 1);
    step();
    // vector WAW on v5, write-back in the same cycle still stalls
    op(4'b0000, 0, 0, 5, 3'b010);
    step();
    chk("v_pend_set", 32'(vpend), 32'h0020);
    #1 chk("v_waw_stall", 32'(stall), 1);
    step();
    wbvv = 1; wbvd = 5;
    #1 chk("v_wb_stall", 32'(stall), 1);
    step();
    wbvv = 0;
    #1 chk("v_issue", 32'(issue), 1);
    step();
    idle();
    #1 chk("v_pend_end", 32'(vpend), 32'h0020);
    wbvv = 1; wbvd = 5;
    step();
    idle();
    chk("pre_ex_stall_cnt", 32'(scnt), 5);
    chk("pre_ex_issue_cnt", 32'(icnt), 6);
    // execute back-pressure for three cycles
    op(4'b0000, 0, 0, 0, 3'b100);
    ex_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("ex_stall", 32'(stall), 1);
      step();
    end
    ex_ready = 1;
    #1 chk("ex_issue", 32'(issue), 1);
    step();
    idle();
    #1 chk("ex_issue_cnt", 32'(icnt), 7);
    chk("ex_stall_cnt", 32'(scnt), 8);
    // flush drops the instruction and blocks refill; r7 stays pending until its write-back
    op(4'b0000, 0, 7, 0, 3'b001);
    step();
    op(4'b0000, 0, 9, 0, 3'b001);
    flush = 1;
    #1 chk("fl_issue", 32'(issue), 0);
    chk("fl_stall", 32'(stall), 0);
    step();
    flush = 0;
    chk("fl_rpend", 32'(rpend), 32'h0080);
    #1 chk("fl_blk1", 32'(issue), 0);
    step();
    wbrv = 1; wbrd = 7;
    #1 chk("fl_blk2", 32'(issue), 0);
    step();
    wbrv = 0;
    #1 chk("fl_issue_after", 32'(issue), 1);
    chk("fl_rpend_clr", 32'(rpend), 0);
    step();
    idle();
    #1 chk("fl_rpend_new", 32'(rpend), 32'h0200);
    chk("fl_issue_cnt", 32'(icnt), 9);
    chk("fl_stall_cnt", 32'(scnt), 10);
    chk("sat_hold", 32'(s_icnt), 7);
    wbrv = 1; wbrd = 9;
    step();
    // async reset while in FLUSH with r4 pending
    op(4'b0000, 0, 4, 0, 3'b001);
    step();
    chk("rs_rpend", 32'(rpend), 32'h0010);
    op(4'b0000, 0, 0, 0, 3'b000);
    flush = 1;
    step();
    flush = 0;
    #1 rst_n = 1'b0;
    #1 chk("rs_issue", 32'(issue), 0);
    chk("rs_stall", 32'(stall), 0);
    chk("rs_rpend0", 32'(rpend), 0);
    chk("rs_scnt", 32'(scnt), 0);
    chk("rs_icnt", 32'(icnt), 0);
    step();
    rst_n = 1'b1;
    #1 chk("rs_run_issue", 32'(issue), 1);
    step();
    idle();
    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
